// File: rtl/cia_pkg.sv
// Shared CIA types: host-side command record and bus-master FSM state encoding.
// Pure declarations, no timing or flow control of their own.
package cia;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
    } mcmd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PEND   = 3'd1,
        ACTIVE = 3'd2,
        RESP   = 3'd3,
        BRESET = 3'd4
    } mstate_t;

endpackage

// File: rtl/cia_phi2_gen.sv
// Free-running PHI2 divider: HALF_DIV clk low then HALF_DIV clk high; strobes mark phase starts.
// *_nxt strobes fire one clk early so registered bus outputs switch together with phi2; no backpressure.
module cia_phi2_gen #(
    parameter int HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    output logic phi2,
    output logic phi2_up,
    output logic phi2_dn,
    output logic phi2_up_nxt,
    output logic phi2_dn_nxt
);

    localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 8'd0;
            phi2 <= 1'b0;
        end else if (wrap) begin
            cnt  <= 8'd0;
            phi2 <= ~phi2;
        end else begin
            cnt  <= cnt + 8'd1;
        end
    end

    assign phi2_up     =  phi2 & (cnt == 8'd0);
    assign phi2_dn     = ~phi2 & (cnt == 8'd0);
    assign phi2_up_nxt = ~phi2 & wrap;
    assign phi2_dn_nxt =  phi2 & wrap;

endmodule

// File: rtl/cia_bus_master.sv
// Single-outstanding CIA register access master with PHI2 generation and bus reset sequencing.
// Latency 1..2 PHI2 cycles + 1 clk to rsp_valid; cmd_ready only in IDLE, no queue.
module cia_bus_master
    import cia::*;
#(
    parameter int HALF_DIV   = 8,
    parameter int RES_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_we,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    input  logic       bus_reset,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       phi2,
    output logic       res_n,
    output logic       cs_n,
    output logic       r_w_n,
    output logic [3:0] addr,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i,
    input  logic       irq_n,
    output logic       irq
);

    localparam int            RW       = $clog2(RES_CYCLES + 1);
    localparam logic [RW-1:0] RES_LAST = RW'(RES_CYCLES);

    mstate_t       state;
    mcmd_t         cmd;
    logic          rst_pend;
    logic          hi_seen;
    logic [RW-1:0] res_cnt;
    logic [RW-1:0] res_start;
    logic [1:0]    irq_sync;
    logic          phi2_up, phi2_dn, phi2_up_nxt, phi2_dn_nxt;

    cia_phi2_gen #(.HALF_DIV(HALF_DIV)) u_phi2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .phi2        (phi2),
        .phi2_up     (phi2_up),
        .phi2_dn     (phi2_dn),
        .phi2_up_nxt (phi2_up_nxt),
        .phi2_dn_nxt (phi2_dn_nxt)
    );

    assign cmd_ready = (state == IDLE);
    assign res_n     = (state != BRESET);
    assign irq       = irq_sync[1];

    // A phi2_dn coinciding with (re)entry into BRESET is already counted.
    assign res_start = phi2_dn ? RW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync <= 2'b00;
        end else begin
            irq_sync <= {irq_sync[0], ~irq_n};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BRESET;
            cmd       <= '0;
            rst_pend  <= 1'b0;
            hi_seen   <= 1'b0;
            res_cnt   <= '0;
            cs_n      <= 1'b1;
            r_w_n     <= 1'b1;
            addr      <= 4'd0;
            data_o    <= 8'd0;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'd0;
            case (state)
                IDLE: begin
                    if (bus_reset) begin
                        state   <= BRESET;
                        res_cnt <= res_start;
                    end else if (cmd_valid) begin
                        cmd   <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (bus_reset) rst_pend <= 1'b1;
                    if (phi2_dn_nxt) begin
                        cs_n    <= 1'b0;
                        r_w_n   <= ~cmd.we;
                        addr    <= cmd.addr;
                        hi_seen <= 1'b0;
                        state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (bus_reset) rst_pend <= 1'b1;
                    if (phi2_up) hi_seen <= 1'b1;
                    if (phi2_up_nxt && cmd.we) begin
                        data_oe <= 1'b1;
                        data_o  <= cmd.wdata;
                    end
                    // Closing edge: last clk of the high phase, also the read sample point.
                    if (phi2_dn_nxt && hi_seen) begin
                        cs_n      <= 1'b1;
                        r_w_n     <= 1'b1;
                        data_oe   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= cmd.we ? 8'd0 : data_i;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rst_pend || bus_reset) begin
                        rst_pend <= 1'b0;
                        res_cnt  <= res_start;
                        state    <= BRESET;
                    end else begin
                        state <= IDLE;
                    end
                end
                BRESET: begin
                    if (bus_reset) begin
                        res_cnt <= res_start;
                    end else if (phi2_dn_nxt && res_cnt == RES_LAST) begin
                        state <= IDLE;
                    end else if (phi2_dn) begin
                        res_cnt <= res_cnt + RW'(1);
                    end
                end
                default: state <= BRESET;
            endcase
        end
    end

endmodule

// File: doc/cia_bus_master.md
CIA_BUS_MASTER -- requirements
Module: cia_bus_master

Interface
REQ-001 Parameter HALF_DIV, default 8, clk cycles per PHI2 half period (legal range 2..255).
REQ-002 Parameter RES_CYCLES, default 16, number of PHI2 cycles for which res_n is held low during a bus reset.
REQ-003 clk  in  1  system clock, the only clock; all logic is on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted on a cycle where cmd_valid & cmd_ready.
REQ-007 cmd_we  in  1  1 = register write, 0 = register read.
REQ-008 cmd_addr  in  4  CIA register address.
REQ-009 cmd_wdata  in  8  write data.
REQ-010 bus_reset  in  1  single-cycle pulse requesting a CIA bus reset.
REQ-011 rsp_valid  out  1  single-cycle pulse marking completion of a command.
REQ-012 rsp_rdata  out  8  read data, valid while rsp_valid is high; 0 for writes.
REQ-013 phi2  out  1  generated PHI2 clock.
REQ-014 res_n  out  1  CIA reset.
REQ-015 cs_n  out  1  chip select.
REQ-016 r_w_n  out  1  read/not-write.
REQ-017 addr  out  4  register address.
REQ-018 data_o  out  8  write data to the CIA.
REQ-019 data_oe  out  1  data bus drive enable.
REQ-020 data_i  in  8  data bus from the CIA.
REQ-021 irq_n  in  1  CIA interrupt line.
REQ-022 irq  out  1  irq_n inverted and passed through a 2-flop synchronizer.

Function
REQ-023 phi2 shall run free: HALF_DIV clk low, then HALF_DIV clk high, repeating; phi2_dn marks the first clk of the low phase and phi2_up the first clk of the high phase.
REQ-024 FSM states shall be IDLE, PEND, ACTIVE, RESP and BRESET.
REQ-025 IDLE: cmd_ready=1; on handshake, latch we/addr/wdata and go to PEND; a bus_reset seen in IDLE goes to BRESET and takes priority over a same-cycle cmd_valid.
REQ-026 PEND: cmd_ready=0; on phi2_dn drive cs_n=0, r_w_n=~we, addr=latched addr, and go to ACTIVE.
REQ-027 ACTIVE spans exactly one PHI2 cycle: low phase, then high phase.
REQ-028 For writes in ACTIVE, data_oe=1 and data_o=wdata from phi2_up until the next phi2_dn.
REQ-029 For reads in ACTIVE, data_i shall be sampled on the last clk of the high phase.
REQ-030 At the ACTIVE-ending phi2_dn: cs_n=1, r_w_n=1, data_oe=0, then go to RESP; addr holds its last value.
REQ-031 RESP lasts one clk: rsp_valid=1, then go to IDLE, or to BRESET if a reset is pending.
REQ-032 Latency from handshake to rsp_valid shall be 1..2 PHI2 cycles plus 1 clk.
REQ-033 Back-to-back commands cannot occupy consecutive PHI2 cycles; at least one idle cycle with cs_n=1 separates them.
REQ-034 A bus_reset pulse arriving in PEND or ACTIVE shall be latched as pending; the transaction completes normally and BRESET follows RESP.
REQ-035 BRESET: res_n=0, cs_n=1, cmd_ready=0.
REQ-036 In BRESET, a counter shall count phi2_dn edges; after RES_CYCLES edges, res_n=1 and the FSM returns to IDLE.
REQ-037 A bus_reset pulse during BRESET shall restart the counter.
REQ-038 The reset counter shall be wide enough for RES_CYCLES with no wrap; the divider counter shall wrap from HALF_DIV-1 to 0.
REQ-039 cmd_valid while cmd_ready=0 shall be ignored and left held by the requester; the block has no queue.

Reset
REQ-040 While rst_n=0, outputs shall be: phi2=0, res_n=0, cs_n=1, r_w_n=1, addr=0, data_o=0, data_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, irq=0.
REQ-041 While rst_n=0, the divider counter and the synchronizer shall be cleared.
REQ-042 On rst_n release, the FSM shall enter BRESET, so the CIA receives RES_CYCLES of reset before the first command.
REQ-043 rst_n assertion mid-transaction shall abort it with no rsp_valid.

Structure
REQ-044 The command struct (we, addr, wdata) and the FSM state enum shall be added to the shared cia package as cia::mcmd_t and cia::mstate_t.
REQ-045 The PHI2 divider, producing phi2, phi2_up and phi2_dn, shall be the sub-module cia_phi2_gen.
REQ-046 The block shall be usable as a bench driver for cia_core and as an on-board host bridge.

Verification
REQ-047 rst_n low then released -> res_n stays low exactly 16 PHI2 cycles (HALF_DIV=8: 256 clk), after which cmd_ready=1.
REQ-048 Write addr 4, data 0x5A -> cs_n=0 for one PHI2 cycle with r_w_n=0; data_oe=1 only in the high phase; a cia_core model shows TA latch lo = 0x5A.
REQ-049 Read addr 0xD with the model driving 0x81 -> rsp_valid pulse with rsp_rdata=0x81; r_w_n=1 throughout.
REQ-050 Two commands issued back-to-back -> at least one PHI2 cycle with cs_n=1 between them; two rsp_valid pulses, in order.
REQ-051 bus_reset pulsed mid-ACTIVE -> the current rsp_valid is still produced, then res_n=0 for 16 PHI2 cycles with cmd_ready=0.
REQ-052 irq_n driven low -> irq=1 within 2 clk; rst_n asserted mid-ACTIVE -> outputs take reset values immediately and no rsp_valid occurs.
